// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the data-memory responder and its storage array.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } lc3b_mem_state;

  localparam int LC3B_MEM_LATENCY_MAX = 15;

endpackage

// File: rtl/lc3b_mem_array.sv
// Word storage for the data-memory responder: one asynchronous read port and
// one byte-masked synchronous write port. Contents are deliberately not reset.
module lc3b_mem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] raddr,
  output lc3b_word             rdata,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  lc3b_mem_wmask        wmask,
  input  lc3b_word             wdata
);

  lc3b_word mem [2**ADDR_BITS];

  assign rdata = mem[raddr];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wmask[0]) mem[waddr][7:0]  <= wdata[7:0];
      if (wmask[1]) mem[waddr][15:8] <= wdata[15:8];
    end
  end

endmodule

// File: rtl/lc3b_mem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY, one-cycle mem_resp.
// Optional read/write access counters are enabled with LC3B_MEM_ACCESS_COUNT_EN.
module lc3b_mem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_wmask,
  input  logic [15:0] mem_wdata,
  output logic        mem_resp,
`ifdef LC3B_MEM_ACCESS_COUNT_EN
  output logic [15:0] mem_rdata,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
`else
  output logic [15:0] mem_rdata
`endif
);

  localparam int CNT_BITS = $clog2(LC3B_MEM_LATENCY_MAX + 1);

  lc3b_mem_state        state;
  lc3b_mem_state        next_state;
  logic [CNT_BITS-1:0]  cnt;
  logic [ADDR_BITS-1:0] req_addr;
  lc3b_word             req_wdata;
  lc3b_mem_wmask        req_wmask;
  logic                 req_write;

  logic                 accept;
  logic [ADDR_BITS-1:0] rd_addr;
  logic                 rd_is_write;
  logic                 load_rdata;
  lc3b_word             rd_word;
  logic                 unused_addr_bits;

  assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

  assign accept   = (state == IDLE) && (mem_read || mem_write);
  assign mem_resp = (state == RESP);

  // With LATENCY==1 the edge entering RESP is also the accept edge, so the
  // read must look at the live request rather than the latched copy.
  always_comb begin
    next_state  = state;
    rd_addr     = req_addr;
    rd_is_write = req_write;
    if (state == IDLE) begin
      rd_addr     = mem_address[ADDR_BITS:1];
      rd_is_write = mem_write;
    end
    case (state)
      IDLE: if (mem_read || mem_write) next_state = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == CNT_BITS'(1)) next_state = RESP;
      RESP: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    load_rdata = (next_state == RESP) && (state != RESP) && !rd_is_write;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wmask <= '0;
      req_write <= 1'b0;
      mem_rdata <= 16'h0000;
    end else begin
      state <= next_state;
      if (accept) begin
        cnt       <= CNT_BITS'(LATENCY - 1);
        req_addr  <= mem_address[ADDR_BITS:1];
        req_wdata <= mem_wdata;
        req_wmask <= mem_wmask;
        req_write <= mem_write;
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_BITS'(1);
      end
      if (load_rdata) mem_rdata <= rd_word;
    end
  end

  // Writes commit only on the edge that ends RESP, so a reset before then discards them.
  lc3b_mem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk  (clk),
    .raddr(rd_addr),
    .rdata(rd_word),
    .we   ((state == RESP) && req_write),
    .waddr(req_addr),
    .wmask(req_wmask),
    .wdata(req_wdata)
  );

`ifdef LC3B_MEM_ACCESS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else if (state == RESP) begin
      if (req_write) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'h0001;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Self-checking bench for lc3b_mem_responder: directed vector table, multi-cycle
// corner sequences and randomized traffic against a word-array reference model.
module tb_lc3b_mem_responder;
  import lc3b_types::*;

  localparam int ADDR_BITS = 8;
  localparam int LATENCY   = 2;
  localparam int WORDS     = 1 << ADDR_BITS;

  logic        clk;
  logic        rst_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_wdata;
  logic        mem_resp;
  logic [15:0] mem_rdata;
`ifdef LC3B_MEM_ACCESS_COUNT_EN
  logic [15:0] rd_count;
  logic [15:0] wr_count;
`endif

  lc3b_mem_responder #(
    .ADDR_BITS(ADDR_BITS),
    .LATENCY  (LATENCY)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_address(mem_address),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
`ifdef LC3B_MEM_ACCESS_COUNT_EN
    .rd_count   (rd_count),
    .wr_count   (wr_count),
`endif
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [1:0]  wmask;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_mem [WORDS];
  logic [15:0] model_rdata;
  int          model_rd_count;
  int          model_wr_count;
  vec_t        vecs [12];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, required, $time);
    end
  endtask

  // Called at a negedge; drives one request, holds it through RESP, then drops it
  // at the following negedge (the mandatory IDLE cycle).
  task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] addr,
                                input logic [1:0] wmask, input logic [15:0] wdata,
                                input logic [15:0] want_rdata);
    int k;
    int idx;
    logic got;
    mem_read    = rd;
    mem_write   = wr;
    mem_address = addr;
    mem_wmask   = wmask;
    mem_wdata   = wdata;
    k   = 0;
    got = 1'b0;
    while (!got && k < 20) begin
      @(negedge clk);
      k++;
      if (mem_resp) got = 1'b1;
    end
    check_output("resp_latency", k, LATENCY);
    if (got) check_output("rdata", mem_rdata, want_rdata);
    idx = (int'(addr) / 2) % WORDS;
    if (wr) begin
      if (wmask[0]) model_mem[idx][7:0]  = wdata[7:0];
      if (wmask[1]) model_mem[idx][15:8] = wdata[15:8];
      model_wr_count++;
    end else begin
      model_rdata = model_mem[idx];
      model_rd_count++;
    end
    @(negedge clk);
    check_output("resp_single_cycle", mem_resp, 1'b0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int idx;
    int n;
    logic [15:0] a;
    logic rd;
    logic wr;

    vecs[0]  = '{1'b0, 1'b1, 16'h0020, 2'b11, 16'hBEEF, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'hBEEF};
    vecs[2]  = '{1'b0, 1'b1, 16'h0020, 2'b01, 16'h1234, 16'hBEEF};
    vecs[3]  = '{1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'hBE34};
    vecs[4]  = '{1'b0, 1'b1, 16'h0020, 2'b10, 16'h1234, 16'hBE34};
    vecs[5]  = '{1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'h1234};
    vecs[6]  = '{1'b0, 1'b1, 16'h0020, 2'b00, 16'hFFFF, 16'h1234};
    vecs[7]  = '{1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'h1234};
    vecs[8]  = '{1'b0, 1'b1, 16'h0202, 2'b11, 16'h5A5A, 16'h1234};
    vecs[9]  = '{1'b1, 1'b0, 16'h0002, 2'b00, 16'h0000, 16'h5A5A};
    vecs[10] = '{1'b1, 1'b1, 16'h0002, 2'b11, 16'h7777, 16'h5A5A};
    vecs[11] = '{1'b1, 1'b0, 16'h0003, 2'b00, 16'h0000, 16'h7777};

    for (int i = 0; i < WORDS; i++) model_mem[i] = 16'h0000;
    model_rdata    = 16'h0000;
    model_rd_count = 0;
    model_wr_count = 0;

    rst_n       = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = 16'h0000;
    mem_wmask   = 2'b00;
    mem_wdata   = 16'h0000;
    repeat (2) @(negedge clk);
    check_output("reset_resp", mem_resp, 1'b0);
    check_output("reset_rdata", mem_rdata, 16'h0000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      apply_stimulus(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wmask, vecs[i].wdata,
                     vecs[i].exp_rdata);

    // Continuously held read: pulses every LATENCY+1 cycles, never adjacent.
    mem_read    = 1'b1;
    mem_address = 16'h0020;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check_output("b2b_resp", mem_resp, (k % (LATENCY + 1)) == LATENCY);
      if (mem_resp) begin
        check_output("b2b_rdata", mem_rdata, model_mem[16'h0020 / 2]);
        model_rd_count++;
      end
    end
    mem_read    = 1'b0;
    model_rdata = model_mem[16'h0020 / 2];
    @(negedge clk);

    // Reset during RESP of a write: pulse drops at once and the write is lost.
    mem_write   = 1'b1;
    mem_address = 16'h0020;
    mem_wmask   = 2'b11;
    mem_wdata   = 16'hAAAA;
    n = 0;
    while (!mem_resp && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output("rst_write_latency", n, LATENCY);
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_resp", mem_resp, 1'b0);
    check_output("rst_mid_rdata", mem_rdata, 16'h0000);
    mem_write      = 1'b0;
    model_rdata    = 16'h0000;
    model_rd_count = 0;
    model_wr_count = 0;
    @(negedge clk);
`ifdef LC3B_MEM_ACCESS_COUNT_EN
    check_output("rst_rd_count", rd_count, 16'h0000);
    check_output("rst_wr_count", wr_count, 16'h0000);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 16'h0020, 2'b00, 16'h0000, 16'h1234);

    // Randomized traffic over 16 words, with random aliasing bits and idle gaps.
    for (int w = 0; w < 16; w++)
      apply_stimulus(1'b0, 1'b1, 16'(w * 2), 2'b11, 16'($urandom), model_rdata);
    for (int t = 0; t < 40; t++) begin
      idx = $urandom_range(0, 15);
      a   = {7'($urandom), 8'(idx), 1'($urandom)};
      n   = $urandom_range(0, 3);
      rd  = (n != 2);
      wr  = (n >= 2);
      apply_stimulus(rd, wr, a, 2'($urandom), 16'($urandom),
                     wr ? model_rdata : model_mem[idx]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

`ifdef LC3B_MEM_ACCESS_COUNT_EN
    check_output("rd_count", rd_count, 32'(model_rd_count));
    check_output("wr_count", wr_count, 32'(model_wr_count));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
